// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and the alignment rule shared by the load/store unit
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [2:0] {IDLE, ACCESS, WRITE, ERR, RESP} state_t;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      return (size == 2'b11) || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane extraction with sign/zero extension, and sub-word merge for stores
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   output logic [31:0] load,
   output logic [31:0] merged
);
   logic [31:0] sh, mask, rep;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      sh = word >> {lane, 3'b000};
      b = sh[7:0];
      h = lane[1] ? word[31:16] : word[15:0];
      load = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
      mask = size == SZ_BYTE ? 32'h0000_00FF << {lane, 3'b000} : size == SZ_HALF ? 32'h0000_FFFF << {lane[1], 4'b0000} : 32'hFFFF_FFFF;
      rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
      merged = (word & ~mask) | (rep & mask);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a single-port word RAM,
// sub-word stores done as read-modify-write, valid/ready on both sides of the core
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_IDX_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);
   state_t            state;
   logic              write, sgn, err;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata, old, rdata, load, merged, word_addr;
   if (MEM_IDX_W < 1 || MEM_IDX_W + 2 > ADDR_W) begin : g_bad_idx
      $error("MEM_IDX_W does not fit inside ADDR_W");
   end
   assign word_addr = 32'({addr[ADDR_W-1:2], 2'b00});
   lsu_lane u_lane (
      .word   (state == WRITE ? old : mem_rd),
      .lane   (addr[1:0]),
      .size   (size),
      .sgn    (sgn),
      .wdata  (wdata),
      .load   (load),
      .merged (merged)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         write <= 1'b0;
         sgn   <= 1'b0;
         size  <= SZ_BYTE;
         addr  <= '0;
         wdata <= '0;
         old   <= '0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               write <= req_write;
               size  <= req_size;
               sgn   <= req_signed;
               addr  <= req_addr;
               wdata <= req_wdata;
               state <= misaligned(req_size, req_addr[1:0]) ? ERR : ACCESS;
            end
            ACCESS: begin
               if (!write) rdata <= load;
               if (write && size != SZ_WORD) old <= mem_rd;
               state <= write && size != SZ_WORD ? WRITE : RESP;
            end
            WRITE: state <= RESP;
            ERR: begin
               err   <= 1'b1;
               state <= RESP;
            end
            RESP: if (resp_ready) begin
               rdata <= '0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // mem_we is gated by rst_n so a reset landing in WRITE never reaches the RAM
   always_comb begin
      req_ready  = rst_n && state == IDLE;
      resp_valid = rst_n && state == RESP;
      resp_rdata = rdata;
      resp_err   = err;
      mem_addr   = (state == ACCESS || state == WRITE) ? word_addr : '0;
      mem_we     = rst_n && ((state == ACCESS && write && size == SZ_WORD) || state == WRITE);
      mem_wd     = !mem_we ? '0 : state == WRITE ? merged : wdata;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, directed stall/reset sequences and random ops against a word-memory model
module tb_load_store_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   int errors = 0, checks = 0;

   typedef struct {
      logic pre; logic [31:0] pw;
      logic wr; logic [1:0] sz; logic sg; logic [31:0] a, wd;
      logic [31:0] er; logic ee; int el, ew; logic [31:0] em;
   } vec_t;
   vec_t tbl [14];

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within 20 cycles", name);
   endtask

   // one full transaction; lat counts edges from acceptance to first resp_valid
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output int wec,
                         output logic [31:0] wdv, output logic [31:0] wav, output int bad);
      int n;
      rd = '0; er = 1'b0; lat = 0; wec = 0; wdv = '0; wav = '0; bad = 0; n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) begin req_valid = 1'b0; timeout("accept"); return; end
      @(posedge clk);
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = 1'b0;
         if (mem_we) begin wec++; wdv = mem_wd; wav = mem_addr; end
         else if (mem_wd !== 32'h0) bad++;
         if (req_ready) bad++;
      end while (!resp_valid && lat < 20);
      if (!resp_valid) begin timeout("response"); return; end
      rd = resp_rdata; er = resp_err;
      @(posedge clk);
   endtask

   // reference: arithmetic on lane values, independent of any FSM
   function automatic void model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] word, output logic [31:0] word_out, output logic [31:0] rd,
                                 output logic er, output int lat, output int wec);
      longint base, u, lanev, v;
      int ln;
      word_out = word; rd = '0; wec = 0; lat = 2;
      er = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      if (er) return;
      base = sz == 2'd0 ? 256 : sz == 2'd1 ? 65536 : 64'h1_0000_0000;
      ln = sz == 2'd0 ? int'(a % 4) : sz == 2'd1 ? int'((a % 4) / 2) : 0;
      u = 1;
      repeat (ln) u = u * base;
      lanev = (longint'(word) / u) % base;
      if (!w) begin
         v = (sg && sz != 2'd2 && lanev >= base / 2) ? lanev - base : lanev;
         rd = v[31:0];
      end else begin
         v = longint'(word) - lanev * u + (longint'(wd) % base) * u;
         word_out = v[31:0];
         wec = 1;
         lat = sz == 2'd2 ? 2 : 3;
      end
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic w, sg, er, eer;
      logic [1:0] sz;
      logic [31:0] a, wd, rd, erd, nw, wdv, wav;
      logic [7:0] idx;
      int lat, wec, bad, elat, ewc;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      tbl[0]  = '{1'b1, 32'h8899AABB, 1'b0, 2'd0, 1'b1, 32'h43, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0, 32'h8899AABB};
      tbl[1]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h40, 32'h0,        32'h0000AABB, 1'b0, 2, 0, 32'h8899AABB};
      tbl[2]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 32'h8899AABB};
      tbl[3]  = '{1'b0, 32'h0,        1'b1, 2'd0, 1'b1, 32'h41, 32'h11,       32'h0,        1'b0, 3, 1, 32'h889911BB};
      tbl[4]  = '{1'b0, 32'h0,        1'b0, 2'd2, 1'b1, 32'h40, 32'h0,        32'h889911BB, 1'b0, 2, 0, 32'h889911BB};
      tbl[5]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h42, 32'h0,        32'h00000099, 1'b0, 2, 0, 32'h889911BB};
      tbl[6]  = '{1'b0, 32'h0,        1'b1, 2'd1, 1'b0, 32'h42, 32'hFFFF1234, 32'h0,        1'b0, 3, 1, 32'h123411BB};
      tbl[7]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h123411BB};
      tbl[8]  = '{1'b0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h42, 32'hDEADBEEF, 32'h0,        1'b1, 2, 0, 32'h123411BB};
      tbl[9]  = '{1'b0, 32'h0,        1'b1, 2'd1, 1'b0, 32'h45, 32'hAAAA,     32'h0,        1'b1, 2, 0, 32'h0};
      tbl[10] = '{1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 2, 0, 32'h123411BB};
      tbl[11] = '{1'b0, 32'h0,        1'b1, 2'd2, 1'b1, 32'h44, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D};
      tbl[12] = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h44, 32'h0,        32'h0000000D, 1'b0, 2, 0, 32'hCAFEF00D};
      tbl[13] = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h46, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 0, 32'hCAFEF00D};

      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      rst_n = 1'b1;
      #1 chk("idle_req_ready", req_ready, 1'b1);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].pre) mem[tbl[i].a[9:2]] = tbl[i].pw;
         do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, er, lat, wec, wdv, wav, bad);
         chk($sformatf("v%0d_rdata", i), rd, tbl[i].er);
         chk($sformatf("v%0d_err", i), er, tbl[i].ee);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].el));
         chk($sformatf("v%0d_we_pulses", i), 32'(wec), 32'(tbl[i].ew));
         chk($sformatf("v%0d_mem_word", i), mem[tbl[i].a[9:2]], tbl[i].em);
         chk($sformatf("v%0d_idle_wd_or_ready", i), 32'(bad), 32'h0);
         if (tbl[i].ew != 0) begin
            chk($sformatf("v%0d_mem_wd", i), wdv, tbl[i].em);
            chk($sformatf("v%0d_mem_addr", i), wav, {tbl[i].a[31:2], 2'b00});
         end
      end

      // stall: response held with resp_ready low
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("stall_first_valid", resp_valid, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_valid", k), resp_valid, 1'b1);
         chk($sformatf("stall%0d_rdata", k), resp_rdata, 32'h123411BB);
         chk($sformatf("stall%0d_req_ready", k), req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("post_stall_req_ready", req_ready, 1'b1);
      chk("post_stall_valid", resp_valid, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_cycle1_valid", resp_valid, 1'b0);
      @(negedge clk);
      chk("b2b_cycle2_valid", resp_valid, 1'b1);
      chk("b2b_rdata", resp_rdata, 32'h000000BB);
      @(posedge clk);

      // reset during the WRITE cycle of a byte store
      mem[8'h20] = 32'h01020304;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h81; req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("write_cycle_we", mem_we, 1'b1);
      rst_n = 1'b0;
      #1 chk("rst_kills_we", mem_we, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_ready", req_ready, 1'b1);
      chk("rst_mid_valid", resp_valid, 1'b0);
      chk("rst_mid_we", mem_we, 1'b0);
      chk("rst_mid_mem_word", mem[8'h20], 32'h01020304);

      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         a = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 15));
         wd = $urandom;
         idx = a[9:2];
         model(w, sz, sg, a, wd, ref_mem[idx], nw, erd, eer, elat, ewc);
         do_req(w, sz, sg, a, wd, rd, er, lat, wec, wdv, wav, bad);
         ref_mem[idx] = nw;
         chk($sformatf("r%0d_rdata", i), rd, erd);
         chk($sformatf("r%0d_err", i), er, eer);
         chk($sformatf("r%0d_latency", i), 32'(lat), 32'(elat));
         chk($sformatf("r%0d_we_pulses", i), 32'(wec), 32'(ewc));
         chk($sformatf("r%0d_mem_word", i), mem[idx], ref_mem[idx]);
         chk($sformatf("r%0d_idle_wd_or_ready", i), 32'(bad), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
